// File: rtl/spi_fsm_pkg.sv
// Shared definitions for the SPI slave control FSM: state encoding, control
// strobe bundle and the per-state output decode.
package spi_fsm_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        GET_ADDR    = 3'd1,
        GOT_ADDR    = 3'd2,
        READ_LOAD   = 3'd3,
        READ_SHIFT  = 3'd4,
        WRITE_GET   = 3'd5,
        WRITE_STORE = 3'd6,
        DONE        = 3'd7
    } stateT;

    typedef struct packed {
        logic addrLatchEn;
        logic srLoad;
        logic dmWriteEn;
        logic misoBufEn;
    } ctrlT;

    function automatic ctrlT decodeCtrl(stateT s);
        ctrlT c;
        c = '0;
        case (s)
            GOT_ADDR:    c.addrLatchEn = 1'b1;
            READ_LOAD:   begin
                c.srLoad    = 1'b1;
                c.misoBufEn = 1'b1;
            end
            READ_SHIFT:  c.misoBufEn   = 1'b1;
            WRITE_STORE: c.dmWriteEn   = 1'b1;
            default:     ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/spi_fsm_if.sv
// Edge pulses and chip select from the input conditioners, control strobes
// out to the SPI slave datapath.
interface spi_fsm_if;
    logic sclkPosEdge;
    logic sclkNegEdge;
    logic csConditioned;
    logic rwBit;
    logic addrLatchEn;
    logic srLoad;
    logic dmWriteEn;
    logic misoBufEn;

    modport master (
        output sclkPosEdge, sclkNegEdge, csConditioned, rwBit,
        input  addrLatchEn, srLoad, dmWriteEn, misoBufEn
    );

    modport slave (
        input  sclkPosEdge, sclkNegEdge, csConditioned, rwBit,
        output addrLatchEn, srLoad, dmWriteEn, misoBufEn
    );
endinterface

// File: rtl/spi_fsm_bit_counter.sv
// Saturating bit counter for one SPI phase; terminal flags the last bit.
module spi_fsm_bit_counter #(
    parameter int unsigned width = 8
) (
    input  logic                         clk,
    input  logic                         clear,
    input  logic                         inc,
    output logic [$clog2(width + 1)-1:0] count,
    output logic                         terminal
);
    localparam int unsigned CW = $clog2(width + 1);
    localparam logic [CW-1:0] LAST = CW'(width - 1);

    assign terminal = (count == LAST);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && !terminal) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/spi_fsm.sv
// SPI slave control FSM: address byte with R/W flag, then one read or write
// data byte, all within a single chip-select assertion.
module spi_fsm
    import spi_fsm_pkg::*;
#(
    parameter int unsigned width = DEFAULT_WIDTH
) (
    input logic  clk,
    input logic  reset,
    spi_fsm_if.slave bus
);
    localparam int unsigned CW = $clog2(width + 1);

    stateT          state;
    ctrlT           ctrl;
    logic [CW-1:0]  count;
    logic           terminal;
    logic           counting;
    logic           bitEdge;
    logic           cntClear;
    logic           cntInc;

    // Only the edge that matters to the current phase is seen; the counter is
    // held clear outside counting states so every counting state starts at 0.
    always_comb begin
        counting = 1'b0;
        bitEdge  = 1'b0;
        case (state)
            GET_ADDR, WRITE_GET: begin
                counting = 1'b1;
                bitEdge  = bus.sclkPosEdge;
            end
            READ_SHIFT: begin
                counting = 1'b1;
                bitEdge  = bus.sclkNegEdge;
            end
            default: ;
        endcase
        cntClear = reset | bus.csConditioned | ~counting | (bitEdge & terminal);
        cntInc   = counting & bitEdge & ~terminal;
    end

    spi_fsm_bit_counter #(.width(width)) bitCounter (
        .clk      (clk),
        .clear    (cntClear),
        .inc      (cntInc),
        .count    (count),
        .terminal (terminal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ctrl  <= '0;
        end else if (state != IDLE && bus.csConditioned) begin
            state <= IDLE;
            ctrl  <= '0;
        end else begin
            ctrl <= decodeCtrl(state);
            case (state)
                IDLE: begin
                    if (!bus.csConditioned) begin
                        state <= GET_ADDR;
                        ctrl  <= decodeCtrl(GET_ADDR);
                    end
                end
                GET_ADDR: begin
                    if (bitEdge && terminal) begin
                        state <= GOT_ADDR;
                        ctrl  <= decodeCtrl(GOT_ADDR);
                    end
                end
                GOT_ADDR: begin
                    if (bus.rwBit) begin
                        state <= READ_LOAD;
                        ctrl  <= decodeCtrl(READ_LOAD);
                    end else begin
                        state <= WRITE_GET;
                        ctrl  <= decodeCtrl(WRITE_GET);
                    end
                end
                READ_LOAD: begin
                    state <= READ_SHIFT;
                    ctrl  <= decodeCtrl(READ_SHIFT);
                end
                READ_SHIFT: begin
                    if (bitEdge && terminal) begin
                        state <= DONE;
                        ctrl  <= decodeCtrl(DONE);
                    end
                end
                WRITE_GET: begin
                    if (bitEdge && terminal) begin
                        state <= WRITE_STORE;
                        ctrl  <= decodeCtrl(WRITE_STORE);
                    end
                end
                WRITE_STORE: begin
                    state <= DONE;
                    ctrl  <= decodeCtrl(DONE);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (count < CW'(width));
        end
    end

    assign bus.addrLatchEn = ctrl.addrLatchEn;
    assign bus.srLoad      = ctrl.srLoad;
    assign bus.dmWriteEn   = ctrl.dmWriteEn;
    assign bus.misoBufEn   = ctrl.misoBufEn;
endmodule

// File: tb/tb_spi_fsm.sv
// Randomized bench for spi_fsm, checked cycle by cycle against a
// transaction-level model of the SPI slave sequencing rules.
module tb_spi_fsm;
    localparam int WIDTH = 8;

    typedef struct packed {
        logic rst;
        logic cs;
        logic pos;
        logic neg;
        logic rw;
    } vecT;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    vecT        stim[$];
    logic [3:0] obsQ[$];   // {addrLatchEn, srLoad, dmWriteEn, misoBufEn}
    logic [3:0] expQ[$];

    // transaction-level model state
    bit mActive = 0, mAddrDone = 0, mRwKnown = 0, mDataLive = 0, mIsRead = 0, mDone = 0;
    int mAddrBits = 0, mDataBits = 0;

    spi_fsm_if bus ();

    spi_fsm #(.width(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic modelStep(input vecT v, output logic [3:0] e);
        e = '0;
        if (v.rst) begin
            mActive = 0;
        end else if (!mActive) begin
            if (!v.cs) begin
                mActive = 1; mAddrBits = 0; mDataBits = 0;
                mAddrDone = 0; mRwKnown = 0; mDataLive = 0; mDone = 0;
            end
        end else if (v.cs) begin
            mActive = 0;
        end else if (!mAddrDone) begin
            if (v.pos) mAddrBits++;
            if (mAddrBits == WIDTH) begin
                mAddrDone = 1;
                e[3] = 1'b1;
            end
        end else if (!mRwKnown) begin
            mRwKnown  = 1;
            mIsRead   = v.rw;
            mDataLive = !v.rw;
            if (v.rw) e = 4'b0101;
        end else if (!mDataLive) begin
            mDataLive = 1;
            e[0] = 1'b1;
        end else if (!mDone) begin
            if (mIsRead ? v.neg : v.pos) mDataBits++;
            if (mDataBits == WIDTH) begin
                mDone = 1;
                if (!mIsRead) e[1] = 1'b1;
            end else if (mIsRead) begin
                e[0] = 1'b1;
            end
        end
    endtask

    task automatic push(input bit rst, input bit cs, input bit pos, input bit neg, input bit rw);
        vecT v;
        v.rst = rst; v.cs = cs; v.pos = pos; v.neg = neg; v.rw = rw;
        stim.push_back(v);
    endtask

    task automatic addIdle(input int n, input bit cs, input bit rw);
        for (int i = 0; i < n; i++) push(0, cs, 0, 0, rw);
    endtask

    task automatic addBits(input int n, input bit rw, input bit simul);
        for (int i = 0; i < n; i++) begin
            addIdle($urandom_range(1, 2), 0, rw);
            if (simul) begin
                push(0, 0, 1, 1, rw);
            end else begin
                push(0, 0, 1, 0, rw);
                addIdle($urandom_range(0, 2), 0, rw);
                push(0, 0, 0, 1, rw);
            end
        end
    endtask

    // abortAfter < 0: complete transaction ending with CS high
    task automatic addTxn(input bit rw, input bit simul, input int abortAfter);
        push(0, 1, 0, 0, rw);
        push(0, 0, 0, 0, rw);
        addBits(WIDTH, rw, simul);
        addIdle(2, 0, rw);
        if (abortAfter >= 0) begin
            addBits(abortAfter, rw, simul);
            addIdle(2, 1, rw);
        end else begin
            addBits(WIDTH, rw, simul);
            addIdle(2, 0, rw);
            addIdle(2, 1, rw);
        end
    endtask

    function automatic int nthEdge(input bit useNeg, input int n, input int from);
        int c = 0;
        for (int i = from; i < stim.size(); i++) begin
            if (useNeg ? stim[i].neg : stim[i].pos) begin
                c++;
                if (c == n) return i;
            end
        end
        return -1;
    endfunction

    task automatic runAll();
        logic [3:0] e;
        obsQ.delete();
        expQ.delete();
        foreach (stim[i]) begin
            reset             = stim[i].rst;
            bus.csConditioned = stim[i].cs;
            bus.sclkPosEdge   = stim[i].pos;
            bus.sclkNegEdge   = stim[i].neg;
            bus.rwBit         = stim[i].rw;
            @(posedge clk);
            modelStep(stim[i], e);
            @(negedge clk);
            obsQ.push_back({bus.addrLatchEn, bus.srLoad, bus.dmWriteEn, bus.misoBufEn});
            expQ.push_back(e);
        end
    endtask

    task automatic test_reset();
        stim.delete();
        push(1, 1, 0, 0, 0);
        push(1, 0, 1, 1, 1);
        push(1, 0, 1, 0, 0);
        addIdle(2, 1, 0);
        runAll();
        foreach (obsQ[i]) begin
            vectors++;
            if (obsQ[i] !== 4'b0000 || obsQ[i] !== expQ[i]) begin
                miscompares++;
                $display("FAIL reset cyc %0d: got %b want %b", i, obsQ[i], 4'b0000);
            end
        end
    endtask

    task automatic test_reset_mid_addr();
        int r, p8, latchAt;
        stim.delete();
        push(0, 1, 0, 0, 0);
        push(0, 0, 0, 0, 0);
        addBits(3, 0, 0);
        r = stim.size();
        push(1, 0, 1, 0, 0);
        push(0, 0, 0, 0, 0);
        addBits(WIDTH, 0, 0);
        addIdle(2, 0, 0);
        addBits(WIDTH, 0, 0);
        addIdle(2, 0, 0);
        addIdle(2, 1, 0);
        runAll();
        p8 = nthEdge(0, WIDTH, r + 1);
        latchAt = -1;
        foreach (obsQ[i]) begin
            vectors++;
            if (obsQ[i] !== expQ[i]) begin
                miscompares++;
                $display("FAIL rstmid trace cyc %0d: got %b want %b", i, obsQ[i], expQ[i]);
            end
            if (obsQ[i][3] && latchAt < 0) latchAt = i;
        end
        vectors++;
        if (obsQ[r] !== 4'b0000) begin
            miscompares++;
            $display("FAIL rstmid outputs after reset: got %b want 0000", obsQ[r]);
        end
        vectors++;
        if (latchAt !== p8) begin
            miscompares++;
            $display("FAIL rstmid latch cycle: got %0d want %0d", latchAt, p8);
        end
    endtask

    task automatic test_write();
        int latchCnt = 0, dmCnt = 0, readCnt = 0, latchAt = -1, dmAt = -1;
        stim.delete();
        addTxn(0, 0, -1);
        runAll();
        foreach (obsQ[i]) begin
            vectors++;
            if (obsQ[i] !== expQ[i]) begin
                miscompares++;
                $display("FAIL write trace cyc %0d: got %b want %b", i, obsQ[i], expQ[i]);
            end
            if (obsQ[i][3]) begin latchCnt++; latchAt = i; end
            if (obsQ[i][1]) begin dmCnt++; dmAt = i; end
            if (obsQ[i][2] || obsQ[i][0]) readCnt++;
        end
        vectors++;
        if (latchCnt !== 1 || latchAt !== nthEdge(0, WIDTH, 0)) begin
            miscompares++;
            $display("FAIL write latch: got %0d pulses at %0d want 1 at %0d", latchCnt, latchAt, nthEdge(0, WIDTH, 0));
        end
        vectors++;
        if (dmCnt !== 1 || dmAt !== nthEdge(0, 2 * WIDTH, 0)) begin
            miscompares++;
            $display("FAIL write dmWriteEn: got %0d pulses at %0d want 1 at %0d", dmCnt, dmAt, nthEdge(0, 2 * WIDTH, 0));
        end
        vectors++;
        if (readCnt !== 0) begin
            miscompares++;
            $display("FAIL write read-path outputs: got %0d cycles want 0", readCnt);
        end
    endtask

    task automatic test_read(input bit simul);
        int p8, n8, srAt = -1, srCnt = 0, dmCnt = 0, misoCnt = 0, misoFirst = -1, misoLast = -1;
        stim.delete();
        addTxn(1, simul, -1);
        runAll();
        p8 = nthEdge(0, WIDTH, 0);
        n8 = nthEdge(1, WIDTH, p8 + 3);
        foreach (obsQ[i]) begin
            vectors++;
            if (obsQ[i] !== expQ[i]) begin
                miscompares++;
                $display("FAIL read%0d trace cyc %0d: got %b want %b", simul, i, obsQ[i], expQ[i]);
            end
            if (obsQ[i][2]) begin srCnt++; srAt = i; end
            if (obsQ[i][1]) dmCnt++;
            if (obsQ[i][0]) begin
                misoCnt++;
                if (misoFirst < 0) misoFirst = i;
                misoLast = i;
            end
        end
        vectors++;
        if (srCnt !== 1 || srAt !== p8 + 1 || dmCnt !== 0) begin
            miscompares++;
            $display("FAIL read%0d strobes: srLoad %0d at %0d dm %0d want 1 at %0d dm 0", simul, srCnt, srAt, dmCnt, p8 + 1);
        end
        vectors++;
        if (misoFirst !== p8 + 1 || misoLast !== n8 - 1 || misoCnt !== n8 - p8 - 1) begin
            miscompares++;
            $display("FAIL read%0d misoBufEn window: got %0d..%0d want %0d..%0d", simul, misoFirst, misoLast, p8 + 1, n8 - 1);
        end
    endtask

    task automatic test_abort();
        int latchCnt = 0, dmCnt = 0, firstEnd;
        stim.delete();
        addTxn(0, 0, 4);
        firstEnd = stim.size();
        addTxn(0, 0, -1);
        runAll();
        foreach (obsQ[i]) begin
            vectors++;
            if (obsQ[i] !== expQ[i]) begin
                miscompares++;
                $display("FAIL abort trace cyc %0d: got %b want %b", i, obsQ[i], expQ[i]);
            end
            if (obsQ[i][3]) latchCnt++;
            if (obsQ[i][1]) begin
                dmCnt++;
                if (i < firstEnd) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL abort dm in aborted txn cyc %0d: got 1 want 0", i);
                end
            end
        end
        vectors++;
        if (latchCnt !== 2 || dmCnt !== 1) begin
            miscompares++;
            $display("FAIL abort strobe counts: latch %0d dm %0d want 2 and 1", latchCnt, dmCnt);
        end
    endtask

    task automatic test_done_hold();
        int holdStart, late = 0;
        stim.delete();
        push(0, 1, 0, 0, 0);
        push(0, 0, 0, 0, 0);
        addBits(WIDTH, 0, 0);
        addIdle(2, 0, 0);
        addBits(WIDTH, 0, 0);
        addIdle(2, 0, 0);
        holdStart = stim.size();
        addBits(5, 0, 0);
        addBits(3, 1, 1);
        addIdle(2, 1, 0);
        runAll();
        foreach (obsQ[i]) begin
            vectors++;
            if (obsQ[i] !== expQ[i]) begin
                miscompares++;
                $display("FAIL donehold trace cyc %0d: got %b want %b", i, obsQ[i], expQ[i]);
            end
            if (i >= holdStart && obsQ[i] !== 4'b0000) late++;
        end
        vectors++;
        if (late !== 0) begin
            miscompares++;
            $display("FAIL donehold outputs after store: got %0d active cycles want 0", late);
        end
    endtask

    task automatic test_simul_write();
        int dmAt = -1;
        stim.delete();
        addTxn(0, 1, -1);
        runAll();
        foreach (obsQ[i]) begin
            vectors++;
            if (obsQ[i] !== expQ[i]) begin
                miscompares++;
                $display("FAIL simulwr trace cyc %0d: got %b want %b", i, obsQ[i], expQ[i]);
            end
            if (obsQ[i][1]) dmAt = i;
        end
        vectors++;
        if (dmAt !== nthEdge(0, 2 * WIDTH, 0)) begin
            miscompares++;
            $display("FAIL simulwr dm cycle: got %0d want %0d", dmAt, nthEdge(0, 2 * WIDTH, 0));
        end
    endtask

    task automatic test_random();
        stim.delete();
        for (int s = 0; s < 8; s++) begin
            addIdle(2, 1, 0);
            for (int c = 0; c < 120; c++) begin
                push($urandom_range(0, 199) == 0,
                     $urandom_range(0, 79) == 0,
                     $urandom_range(0, 9) < 4,
                     $urandom_range(0, 9) < 4,
                     1'($urandom_range(0, 1)));
            end
        end
        addIdle(2, 1, 0);
        runAll();
        foreach (obsQ[i]) begin
            vectors++;
            if (obsQ[i] !== expQ[i] || !$onehot0(obsQ[i][3:1])) begin
                miscompares++;
                $display("FAIL random trace cyc %0d: got %b want %b", i, obsQ[i], expQ[i]);
            end
        end
    endtask

    initial begin
        reset             = 1'b1;
        bus.csConditioned = 1'b1;
        bus.sclkPosEdge   = 1'b0;
        bus.sclkNegEdge   = 1'b0;
        bus.rwBit         = 1'b0;
        @(negedge clk);
        test_reset();
        test_reset_mid_addr();
        test_write();
        test_read(0);
        test_abort();
        test_done_hold();
        test_read(1);
        test_simul_write();
        test_random();
        test_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
